// File: rtl/mdio_pkg.sv
// mdio_pkg: shared definitions for the MDIO management master.
//   - OP / ST encodings for Clause 22 and Clause 45 frames
//   - frame field widths and the FSM state enum
//   - cmd_t: the latched command fields
//   - frame_bit(): the {oe, o} pair the master presents for a given frame position
package mdio_pkg;

  localparam int PHYAD_W  = 5;
  localparam int REGAD_W  = 5;
  localparam int DATA_W   = 16;
  localparam int TA_W     = 2;
  localparam int BITCNT_W = 5;

  localparam logic [1:0] ST_C22 = 2'b01;
  localparam logic [1:0] ST_C45 = 2'b00;

  localparam logic [1:0] OP22_WR    = 2'b01;
  localparam logic [1:0] OP22_RD    = 2'b10;
  localparam logic [1:0] OP45_ADDR  = 2'b00;
  localparam logic [1:0] OP45_WR    = 2'b01;
  localparam logic [1:0] OP45_RD    = 2'b11;
  localparam logic [1:0] OP45_RDINC = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_ST_OP, S_ADDR, S_TA, S_DATA, S_GAP
  } state_e;

  typedef struct packed {
    logic               c45;
    logic [1:0]         op;
    logic [PHYAD_W-1:0] phyad;
    logic [REGAD_W-1:0] regad;
    logic [DATA_W-1:0]  wrdata;
  } cmd_t;

  // Read-type frames release the bus from TA onwards.
  function automatic logic is_read(input cmd_t c);
    if (c.c45) return (c.op == OP45_RD) || (c.op == OP45_RDINC);
    return c.op == OP22_RD;
  endfunction

  // Returns {oe, o} for bit position idx (counting down, MSB first) of state s.
  // Positions where the master does not drive return {0, 1} (released, idle high).
  function automatic logic [1:0] frame_bit(input state_e s, input logic [3:0] idx,
                                           input cmd_t c);
    logic [3:0]                 st_op;
    logic [PHYAD_W+REGAD_W-1:0] addr;
    logic [1:0]                 res;
    st_op = {(c.c45 ? ST_C45 : ST_C22), c.op};
    addr  = {c.phyad, c.regad};
    res   = 2'b01;
    case (s)
      S_PRE:   res = 2'b11;
      S_ST_OP: res = {1'b1, st_op[idx[1:0]]};
      S_ADDR:  res = {1'b1, addr[idx]};
      S_TA:    res = is_read(c) ? 2'b01 : {1'b1, idx[0]};   // drives 1 then 0
      S_DATA:  res = is_read(c) ? 2'b01 : {1'b1, c.wrdata[idx]};
      default: res = 2'b01;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mdio_clkgen.sv
// mdio_clkgen: MDC divider. While i_en is high a counter runs 0..CLK_DIV-1 and
// o_mdc toggles at terminal count; when i_en is low the divider sits at 0 with
// o_mdc low so the first rise lands CLK_DIV cycles after enable.
//   clk, rst        : system clock, synchronous active-high reset
//   i_en            : run the divider
//   o_mdc           : management clock
//   o_mdc_rise/fall : high in the clk cycle whose ending edge raises/lowers o_mdc
module mdio_clkgen #(
  parameter int CLK_DIV = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic i_en,
  output logic o_mdc,
  output logic o_mdc_rise,
  output logic o_mdc_fall
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          r_mdc;
  logic          w_tc;

  assign w_tc       = i_en && (r_cnt == CW'(CLK_DIV - 1));
  assign o_mdc      = r_mdc;
  assign o_mdc_rise = w_tc && !r_mdc;
  assign o_mdc_fall = w_tc &&  r_mdc;

  always_ff @(posedge clk) begin
    if (rst || !i_en) begin
      r_cnt <= '0;
      r_mdc <= 1'b0;
    end else if (w_tc) begin
      r_cnt <= '0;
      r_mdc <= ~r_mdc;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mdio_master_ng.sv
// mdio_master_ng: MDIO/MIIM management master, Clause 22 and Clause 45 frames.
//   clk, rst                 : system clock, synchronous active-high reset
//   cmd_valid/cmd_ready      : command handshake, accepted only in IDLE
//   cmd_c45, cmd_op          : frame type and OP field
//   cmd_phyad, cmd_regad     : PHYAD/PRTAD and REGAD/DEVAD
//   cmd_wrdata               : write data or C45 register address
//   rd_data/rd_valid/rd_err  : read result, one-cycle strobe, turnaround error
//   cmd_err                  : one-cycle strobe when an illegal command is dropped
//   busy                     : frame or inter-frame gap in progress
//   mdc, mdio_o, mdio_oe     : management clock and tristate data out
//   mdio_i                   : pad input (externally pulled up)
module mdio_master_ng
  import mdio_pkg::*;
#(
  parameter int CLK_DIV      = 5,
  parameter int PREAMBLE_LEN = 32,
  parameter int C45_EN       = 1,
  parameter int IDLE_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_c45,
  input  logic [1:0]        cmd_op,
  input  logic [PHYAD_W-1:0] cmd_phyad,
  input  logic [REGAD_W-1:0] cmd_regad,
  input  logic [DATA_W-1:0] cmd_wrdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_err,
  output logic              cmd_err,
  output logic              busy,
  output logic              mdc,
  output logic              mdio_o,
  output logic              mdio_oe,
  input  logic              mdio_i
);

  state_e              r_state, w_nstate;
  logic [BITCNT_W-1:0] r_bitcnt, w_ncnt;
  cmd_t                r_cmd, w_cmd_in, w_cmd_sel;
  logic                w_accept, w_illegal, w_busy, w_mdc_rise, w_mdc_fall, w_start;
  logic [1:0]          w_nbit;
  logic                r_mdio_o, r_mdio_oe, r_err;
  logic                r_rd_valid, r_rd_err, r_cmd_err;
  logic [DATA_W-2:0]   r_rd_sh;
  logic [DATA_W-1:0]   r_rd_data;

  assign w_busy    = (r_state != S_IDLE);
  assign cmd_ready = (r_state == S_IDLE) && !rst;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_cmd_in  = {cmd_c45, cmd_op, cmd_phyad, cmd_regad, cmd_wrdata};
  assign w_illegal = cmd_c45 ? (C45_EN == 0)
                             : !((cmd_op == OP22_WR) || (cmd_op == OP22_RD));
  assign w_start   = w_accept && !w_illegal;

  mdio_clkgen #(.CLK_DIV(CLK_DIV)) u_clkgen (
    .clk        (clk),
    .rst        (rst),
    .i_en       (w_busy),
    .o_mdc      (mdc),
    .o_mdc_rise (w_mdc_rise),
    .o_mdc_fall (w_mdc_fall)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_bitcnt <= '0;
    end else begin
      r_state  <= w_nstate;
      r_bitcnt <= w_ncnt;
    end
  end

  // Next state: every frame bit is one MDC cycle and ends on an mdc fall; the
  // bit counter counts down through a field and is reloaded on state entry.
  always_comb begin
    w_nstate  = r_state;
    w_ncnt    = r_bitcnt;
    w_cmd_sel = r_cmd;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_cmd_sel = w_cmd_in;   // fields are not registered yet at accept
          if (PREAMBLE_LEN > 0) begin
            w_nstate = S_PRE;
            w_ncnt   = BITCNT_W'(PREAMBLE_LEN - 1);
          end else begin
            w_nstate = S_ST_OP;
            w_ncnt   = BITCNT_W'(3);
          end
        end
      end
      default: begin
        if (w_mdc_fall) begin
          if (r_bitcnt != '0) begin
            w_ncnt = r_bitcnt - 1'b1;
          end else begin
            case (r_state)
              S_PRE:   begin w_nstate = S_ST_OP; w_ncnt = BITCNT_W'(3); end
              S_ST_OP: begin w_nstate = S_ADDR;  w_ncnt = BITCNT_W'(PHYAD_W + REGAD_W - 1); end
              S_ADDR:  begin w_nstate = S_TA;    w_ncnt = BITCNT_W'(TA_W - 1); end
              S_TA:    begin w_nstate = S_DATA;  w_ncnt = BITCNT_W'(DATA_W - 1); end
              S_DATA:  begin w_nstate = S_GAP;   w_ncnt = BITCNT_W'(IDLE_BITS - 1); end
              default: begin w_nstate = S_IDLE;  w_ncnt = '0; end
            endcase
          end
        end
      end
    endcase
    w_nbit = frame_bit(w_nstate, w_ncnt[3:0], w_cmd_sel);
  end

  // Datapath: pad drive, read sampling and result strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cmd      <= '0;
      r_mdio_o   <= 1'b1;
      r_mdio_oe  <= 1'b0;
      r_err      <= 1'b0;
      r_rd_sh    <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_cmd_err  <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
      r_cmd_err  <= 1'b0;
      if (w_accept) begin
        r_cmd     <= w_cmd_in;
        r_err     <= 1'b0;
        r_cmd_err <= w_illegal;
      end
      // Outputs move with the mdc fall so the PHY sees stable data at the rise.
      if (w_start || (w_busy && w_mdc_fall))
        {r_mdio_oe, r_mdio_o} <= w_nbit;
      // Input is sampled in the cycle that raises mdc.
      if (w_busy && w_mdc_rise && is_read(r_cmd)) begin
        if (r_state == S_TA && r_bitcnt == '0)
          r_err <= mdio_i;    // second TA bit must be driven 0 by the PHY
        if (r_state == S_DATA) begin
          r_rd_sh <= {r_rd_sh[DATA_W-3:0], mdio_i};
          if (r_bitcnt == '0) begin
            r_rd_data  <= {r_rd_sh, mdio_i};
            r_rd_valid <= 1'b1;
            r_rd_err   <= r_err;
          end
        end
      end
    end
  end

  assign busy     = w_busy;
  assign mdio_o   = r_mdio_o;
  assign mdio_oe  = r_mdio_oe;
  assign rd_data  = r_rd_data;
  assign rd_valid = r_rd_valid;
  assign rd_err   = r_rd_err;
  assign cmd_err  = r_cmd_err;

endmodule
